// File: rtl/uart_reg_ctrl.sv
// UART byte-stream command decoder driving a small 8-bit register bank.
// Optional inter-byte timeout: define UART_REG_CTRL_TIMEOUT_EN to build it.

module uart_reg_bank #(
  parameter int N_REGS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [7:0]            addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  output logic                  hit,
  output logic [8*N_REGS-1:0]   regs_out
);

  localparam logic [8:0] N_REGS_9 = 9'(N_REGS);

  assign hit = ({1'b0, addr} < N_REGS_9);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_out <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (addr == 8'(i)) regs_out[8*i +: 8] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < N_REGS; i++) begin
      if (addr == 8'(i)) rdata = regs_out[8*i +: 8];
    end
  end

endmodule

// state       | meaning
// ST_IDLE     | waiting for a command byte ('W' or 'R')
// ST_GET_ADDR | command latched, waiting for the address byte
// ST_GET_DATA | write address latched, waiting for the data byte
// ST_RESP     | response byte presented on tx, waiting for tx_tready
module uart_reg_ctrl #(
  parameter int N_REGS         = 4,
  parameter int TIMEOUT_CYCLES = 20_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_tdata,
  input  logic                  rx_tvalid,
  output logic                  rx_tready,
  output logic [7:0]            tx_tdata,
  output logic                  tx_tvalid,
  input  logic                  tx_tready,
  output logic [8*N_REGS-1:0]   regs_out,
  output logic                  frame_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_GET_ADDR = 2'd1;
  localparam logic [1:0] ST_GET_DATA = 2'd2;
  localparam logic [1:0] ST_RESP     = 2'd3;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] RESP_OK  = 8'h4B;
  localparam logic [7:0] RESP_BAD = 8'h3F;

  if (N_REGS < 1 || N_REGS > 256) begin : g_bad_n_regs
    $error("uart_reg_ctrl: N_REGS must be in 1..256");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_reg_ctrl: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0] state;
  logic       is_wr_q;
  logic [7:0] addr_q;
  logic       accept;
  logic       in_frame;
  logic       timeout;
  logic [7:0] bank_addr;
  logic [7:0] bank_rdata;
  logic       bank_hit;
  logic       bank_wr;

  assign rx_tready = !rst && (state != ST_RESP);
  assign tx_tvalid = (state == ST_RESP);
  assign accept    = rx_tvalid && rx_tready;
  assign in_frame  = (state == ST_GET_ADDR) || (state == ST_GET_DATA);

  // Reads decode the incoming addr byte directly; writes use the latched addr.
  assign bank_addr = (state == ST_GET_DATA) ? addr_q : rx_tdata;
  assign bank_wr   = accept && (state == ST_GET_DATA);

  uart_reg_bank #(.N_REGS(N_REGS)) u_bank (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bank_wr),
    .addr     (bank_addr),
    .wdata    (rx_tdata),
    .rdata    (bank_rdata),
    .hit      (bank_hit),
    .regs_out (regs_out)
  );

`ifdef UART_REG_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt;

  assign timeout = in_frame && !accept && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= timeout;
      if (!in_frame || accept || timeout) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timeout   = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      is_wr_q  <= 1'b0;
      addr_q   <= 8'h00;
      tx_tdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (rx_tdata == CMD_WR || rx_tdata == CMD_RD) begin
              is_wr_q <= (rx_tdata == CMD_WR);
              state   <= ST_GET_ADDR;
            end else begin
              tx_tdata <= RESP_BAD;
              state    <= ST_RESP;
            end
          end
        end
        ST_GET_ADDR: begin
          if (accept) begin
            addr_q <= rx_tdata;
            if (is_wr_q) begin
              state <= ST_GET_DATA;
            end else begin
              tx_tdata <= bank_hit ? bank_rdata : RESP_BAD;
              state    <= ST_RESP;
            end
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        ST_GET_DATA: begin
          if (accept) begin
            tx_tdata <= bank_hit ? RESP_OK : RESP_BAD;
            state    <= ST_RESP;
          end else if (timeout) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          if (tx_tready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_ctrl.sv
// Self-checking bench for uart_reg_ctrl against a frame-level reference model.
// Timeout expectations follow UART_REG_CTRL_TIMEOUT_EN as the DUT is built.

module tb_uart_reg_ctrl;

  localparam int N_REGS = 4;
  localparam int TO     = 20;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [7:0]          rx_tdata = 8'h00;
  logic                rx_tvalid = 1'b0;
  logic                rx_tready;
  logic [7:0]          tx_tdata;
  logic                tx_tvalid;
  logic                tx_tready = 1'b1;
  logic [8*N_REGS-1:0] regs_out;
  logic                frame_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] model_regs [N_REGS];

  uart_reg_ctrl #(.N_REGS(N_REGS), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_tdata  (rx_tdata),
    .rx_tvalid (rx_tvalid),
    .rx_tready (rx_tready),
    .tx_tdata  (tx_tdata),
    .tx_tvalid (tx_tvalid),
    .tx_tready (tx_tready),
    .regs_out  (regs_out),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < N_REGS; i++) model_regs[i] = 8'h00;
  endfunction

  // Whole-frame reference: returns the expected response and applies any write.
  function automatic logic [7:0] model_frame(input logic [7:0] c, input logic [7:0] a,
                                             input logic [7:0] d);
    int ai;
    ai = int'(a);
    if (c == 8'h52) return (ai < N_REGS) ? model_regs[ai] : 8'h3F;
    if (c == 8'h57) begin
      if (ai < N_REGS) begin
        model_regs[ai] = d;
        return 8'h4B;
      end
      return 8'h3F;
    end
    return 8'h3F;
  endfunction

  function automatic logic [8*N_REGS-1:0] model_flat();
    logic [8*N_REGS-1:0] f;
    for (int i = 0; i < N_REGS; i++) f[8*i +: 8] = model_regs[i];
    return f;
  endfunction

  function automatic int frame_len(input logic [7:0] c);
    return (c == 8'h57) ? 3 : (c == 8'h52) ? 2 : 1;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_tdata  = b;
    rx_tvalid = 1'b1;
    while (!rx_tready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!rx_tready) begin
      errors++;
      $display("FAIL send_byte_wait: rx_tready=%b required 1 (byte %h)", rx_tready, b);
      rx_tvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rx_tvalid = 1'b0;
  endtask

  // Drives one frame; samples the response on the cycle after the last byte,
  // optionally stalls tx_tready for 'delay' cycles, then completes the handshake.
  task automatic run_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input int delay, output logic [7:0] resp, output logic got,
                           output logic [8*N_REGS-1:0] rg);
    int nb;
    nb = frame_len(c);
    tx_tready = (delay == 0);
    send_byte(c);
    if (nb > 1) send_byte(a);
    if (nb > 2) send_byte(d);
    got  = tx_tvalid;
    resp = tx_tdata;
    rg   = regs_out;
    for (int k = 0; k < delay; k++) begin
      @(posedge clk); #1;
    end
    tx_tready = 1'b1;
    if (got) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rx_tready !== 1'b0) begin errors++; $display("FAIL reset_rx_tready: got %b need 0", rx_tready); end
    checks++;
    if (tx_tvalid !== 1'b0 || tx_tdata !== 8'h00) begin
      errors++; $display("FAIL reset_tx: got valid=%b data=%h need 0/00", tx_tvalid, tx_tdata);
    end
    checks++;
    if (regs_out !== '0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got regs=%h err=%b need 0/0", regs_out, frame_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rx_tready !== 1'b1) begin errors++; $display("FAIL post_reset_rx_tready: got %b need 1", rx_tready); end
  endtask

  task automatic test_write();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg; logic [7:0] e;
    e = model_frame(8'h57, 8'h00, 8'hA5);
    run_frame(8'h57, 8'h00, 8'hA5, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== e) begin errors++; $display("FAIL write_resp: got valid=%b data=%h need 1/%h", g, r, e); end
    checks++;
    if (rg[7:0] !== 8'hA5) begin errors++; $display("FAIL write_visible: got reg0=%h need a5", rg[7:0]); end
    checks++;
    if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL write_handshake: got tx_tvalid=%b need 0", tx_tvalid); end
  endtask

  task automatic test_read();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg; logic [7:0] e;
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h03; addrs[2] = 8'h04;
    for (int i = 0; i < 3; i++) begin
      e = model_frame(8'h52, addrs[i], 8'h00);
      run_frame(8'h52, addrs[i], 8'h00, 0, r, g, rg);
      checks++;
      if (g !== 1'b1 || r !== e) begin
        errors++; $display("FAIL read_resp addr=%h: got valid=%b data=%h need 1/%h", addrs[i], g, r, e);
      end
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg;
    logic [7:0] addrs [2];
    run_frame(8'h41, 8'h00, 8'h00, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== 8'h3F) begin errors++; $display("FAIL bad_cmd: got valid=%b data=%h need 1/3f", g, r); end
    addrs[0] = 8'h09; addrs[1] = 8'h04;
    for (int i = 0; i < 2; i++) begin
      run_frame(8'h57, addrs[i], 8'h11, 0, r, g, rg);
      checks++;
      if (g !== 1'b1 || r !== 8'h3F) begin
        errors++; $display("FAIL oor_write addr=%h: got valid=%b data=%h need 1/3f", addrs[i], g, r);
      end
      checks++;
      if (regs_out !== model_flat()) begin
        errors++; $display("FAIL oor_write_regs: got %h need %h", regs_out, model_flat());
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg; logic [7:0] e;
    int bad;
    bad = 0;
    e = model_frame(8'h57, 8'h02, 8'h3C);
    tx_tready = 1'b0;
    send_byte(8'h57); send_byte(8'h02); send_byte(8'h3C);
    rx_tdata = 8'h52; rx_tvalid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (tx_tvalid !== 1'b1 || tx_tdata !== e || rx_tready !== 1'b0) begin
        if (bad == 0) $display("FAIL backpressure_hold cycle %0d: got valid=%b data=%h rdy=%b need 1/%h/0",
                               k, tx_tvalid, tx_tdata, rx_tready, e);
        bad++;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) errors++;
    rx_tvalid = 1'b0;
    tx_tready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (tx_tvalid !== 1'b0) begin errors++; $display("FAIL backpressure_release: got tx_tvalid=%b need 0", tx_tvalid); end
    e = model_frame(8'h52, 8'h02, 8'h00);
    run_frame(8'h52, 8'h02, 8'h00, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== e) begin errors++; $display("FAIL backpressure_readback: got %b/%h need 1/%h", g, r, e); end
  endtask

  task automatic test_timeout();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg; logic [7:0] e;
    int n_err, n_tx, exp_err;
`ifdef UART_REG_CTRL_TIMEOUT_EN
    exp_err = 1;
`else
    exp_err = 0;
`endif
    n_err = 0; n_tx = 0;
    send_byte(8'h57);
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (frame_err === 1'b1) n_err++;
      if (tx_tvalid === 1'b1) n_tx++;
    end
    checks++;
    if (n_err != exp_err) begin errors++; $display("FAIL timeout_frame_err: got %0d pulses need %0d", n_err, exp_err); end
    checks++;
    if (n_tx != 0) begin errors++; $display("FAIL timeout_no_resp: got %0d resp cycles need 0", n_tx); end
    if (exp_err == 0) begin
      // Without the timeout the frame is still open: finish it harmlessly.
      send_byte(8'h09); send_byte(8'h11);
      checks++;
      if (tx_tvalid !== 1'b1 || tx_tdata !== 8'h3F) begin
        errors++; $display("FAIL no_timeout_finish: got %b/%h need 1/3f", tx_tvalid, tx_tdata);
      end
      @(posedge clk); #1;
    end
    e = model_frame(8'h52, 8'h00, 8'h00);
    run_frame(8'h52, 8'h00, 8'h00, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== e) begin errors++; $display("FAIL timeout_readback: got %b/%h need 1/%h", g, r, e); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg;
    send_byte(8'h57); send_byte(8'h01);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (rx_tready !== 1'b0) begin errors++; $display("FAIL midreset_rx_tready: got %b need 0", rx_tready); end
    rst = 1'b0;
    checks++;
    if (regs_out !== '0 || tx_tvalid !== 1'b0) begin
      errors++; $display("FAIL midreset_state: got regs=%h valid=%b need 0/0", regs_out, tx_tvalid);
    end
    run_frame(8'hFF, 8'h00, 8'h00, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== 8'h3F) begin errors++; $display("FAIL midreset_ff: got %b/%h need 1/3f", g, r); end
    checks++;
    if (regs_out !== '0) begin errors++; $display("FAIL midreset_no_write: got %h need 0", regs_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r; logic g; logic [8*N_REGS-1:0] rg; logic [7:0] e;
    e = model_frame(8'h57, 8'h01, 8'h5A);
    run_frame(8'h57, 8'h01, 8'h5A, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== e || rx_tready !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got %b/%h rdy=%b need 1/%h rdy=1", g, r, rx_tready, e);
    end
    e = model_frame(8'h52, 8'h01, 8'h00);
    run_frame(8'h52, 8'h01, 8'h00, 0, r, g, rg);
    checks++;
    if (g !== 1'b1 || r !== e) begin errors++; $display("FAIL b2b_second: got %b/%h need 1/%h", g, r, e); end
  endtask

  task automatic test_random();
    logic [7:0] c, a, d, r, e; logic g; logic [8*N_REGS-1:0] rg;
    int sel;
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 7));
      c = (sel < 3) ? 8'h57 : (sel < 6) ? 8'h52 : 8'($urandom);
      a = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
      d = 8'($urandom);
      e = model_frame(c, a, d);
      run_frame(c, a, d, int'($urandom_range(0, 3)), r, g, rg);
      checks++;
      if (g !== 1'b1 || r !== e) begin
        errors++; $display("FAIL random_resp %h/%h/%h: got %b/%h need 1/%h", c, a, d, g, r, e);
      end
      checks++;
      if (regs_out !== model_flat()) begin
        errors++; $display("FAIL random_regs: got %h need %h", regs_out, model_flat());
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_backpressure();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_ctrl.md
# uart_reg_ctrl

Byte-level command decoder that sits directly downstream of the UART receiver and upstream of the UART transmitter. It consumes received bytes as an AXI-Stream-style byte stream and parses fixed-length read/write frames. Frames access a small bank of 8-bit control registers, which drive board outputs such as the LED bank. Each frame produces exactly one single-byte response toward the transmitter, except frames dropped by timeout.

## Interface
Parameters:
- N_REGS, 4, number of 8-bit registers; legal range 1..256.
- TIMEOUT_CYCLES, 20_000, maximum clock cycles allowed between bytes of one frame; minimum 2.

Ports:
- clk  input  1  system clock (100 MHz on the board).
- rst  input  1  synchronous, active-high reset.
- rx_tdata  input  8  received byte.
- rx_tvalid  input  1  received byte valid.
- rx_tready  output  1  decoder accepts a byte this cycle.
- tx_tdata  output  8  response byte.
- tx_tvalid  output  1  response byte valid.
- tx_tready  input  1  transmitter accepts the response byte.
- regs_out  output  8*N_REGS  register bank, flattened; reg i occupies bits [8i+7:8i].
- frame_err  output  1  one-cycle pulse on a dropped frame (timeout only).

## Operation
- Frame formats:
  - Write: 0x57 ('W'), addr, data.
  - Read: 0x52 ('R'), addr.
- States and transitions:
  - IDLE: on an accepted byte, 0x57/0x52 -> GET_ADDR (latch the command). Any other value -> RESP with 0x3F ('?').
  - GET_ADDR: on an accepted byte, latch addr.
    - Read, addr < N_REGS -> RESP with reg[addr].
    - Read, addr >= N_REGS -> RESP with 0x3F.
    - Write -> GET_DATA.
  - GET_DATA: on an accepted byte:
    - addr < N_REGS: reg[addr] <= data on that same clock edge; go to RESP with 0x4B ('K').
    - addr >= N_REGS: no register changes; go to RESP with 0x3F.
  - RESP: tx_tvalid=1, tx_tdata held stable. Leave to IDLE on the cycle tx_tvalid && tx_tready.
- rx_tready = !rst && (state != RESP). The decoder never accepts a byte while a response is pending.
- A byte transfers only when rx_tvalid && rx_tready are both high at a rising clk edge.
- A read returns the register value as of the edge that accepted the addr byte.
- Out-of-range checks are unsigned compares against the full 8-bit addr. There is no wrap or modulo.

## Timing
- Reset values (outputs): all regs_out = 0; tx_tvalid = 0; tx_tdata = 0x00; frame_err = 0.
- Reset values (internal): state = IDLE; timeout counter = 0.
- rx_tready is 0 while rst is high.
- Reset asserted mid-frame or while in RESP discards the frame and any pending response. No response is emitted after reset.
- Latency: tx_tvalid rises on the cycle after the edge that accepted the final frame byte, i.e. 1-cycle latency.
- A written register is visible on regs_out the cycle after the data byte is accepted.
- Back-to-back frames: a new command byte can be accepted on the cycle after the response handshake completes.
- Timeout counter:
  - Counts only in GET_ADDR and GET_DATA.
  - Cleared on every accepted byte and on entering IDLE.
  - When it reaches TIMEOUT_CYCLES-1 with no byte accepted: return to IDLE, pulse frame_err for 1 cycle, send no response.
  - If a byte is accepted on that same cycle, the byte wins and no timeout occurs.

## Configuration
- UART_REG_CTRL_TIMEOUT_EN defined: inter-byte timeout logic and frame_err behave as described above.
- Not defined: no timeout counter is built, partial frames wait indefinitely, and frame_err is tied to 0. TIMEOUT_CYCLES is ignored.

## Test plan
- Write: send 0x57,0x00,0xA5 -> response 0x4B; regs_out[7:0]=0xA5 on the cycle after the data byte is accepted.
- Read: after the write above, send 0x52,0x00 -> response 0xA5. Send 0x52,0x04 with N_REGS=4 -> response 0x3F.
- Bad command and out-of-range write:
  - Send 0x41 -> response 0x3F.
  - Send 0x57,0x09,0x11 -> response 0x3F; regs_out unchanged.
- Backpressure: hold tx_tready=0 for 50 cycles after a write frame.
  - tx_tvalid stays 1 with tx_tdata=0x4B stable, and rx_tready=0 throughout.
  - A rx_tvalid byte offered during that window is not consumed.
- Timeout (UART_REG_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=20): send 0x57, then idle for 25 cycles.
  - frame_err pulses once; no response is emitted.
  - A following 0x52,0x00 frame returns reg0.
- Reset mid-frame: send 0x57,0x01 and assert rst for 1 cycle, then send 0xFF.
  - No register is written.
  - 0xFF is decoded as a bad command -> response 0x3F.
